// File: rtl/letter_entry_buffer.sv
// Letter entry front end: synchronizes and debounces ENTER/CLEAR, then keeps
// the last four switch codes in a scrolling buffer for the HEX0..HEX3 decoders.
module letter_entry_buffer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CODE_W          = 6
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [0:CODE_W-1] SW,
  input  logic [0:1]        KEY,
  output logic [0:CODE_W-1] CODE0,
  output logic [0:CODE_W-1] CODE1,
  output logic [0:CODE_W-1] CODE2,
  output logic [0:CODE_W-1] CODE3,
  output logic [0:3]        VALID,
  output logic [2:0]        COUNT,
  output logic              FULL,
  output logic              PUSH_ACK
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [0:1]        key_s1, key_s2, key_db, key_db_d;
  logic [0:CODE_W-1] sw_s1, sw_s2;
  logic              enter_p, clear_p;

  // Keys synchronize to the released level so reset never looks like a press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt <= '0;
        lvl <= 1'b1;
      end else if (key_s2[k] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl <= key_s2[k];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign key_db[k] = lvl;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_db_d <= 2'b11;
      enter_p  <= 1'b0;
      clear_p  <= 1'b0;
    end else begin
      key_db_d <= key_db;
      enter_p  <= key_db_d[0] & ~key_db[0];
      clear_p  <= key_db_d[1] & ~key_db[1];
    end
  end

  // Clear wins over a simultaneous enter; a full buffer keeps scrolling.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      CODE0    <= '0;
      CODE1    <= '0;
      CODE2    <= '0;
      CODE3    <= '0;
      VALID    <= '0;
      COUNT    <= '0;
      PUSH_ACK <= 1'b0;
    end else if (clear_p) begin
      CODE0    <= '0;
      CODE1    <= '0;
      CODE2    <= '0;
      CODE3    <= '0;
      VALID    <= '0;
      COUNT    <= '0;
      PUSH_ACK <= 1'b0;
    end else if (enter_p) begin
      CODE3    <= CODE2;
      CODE2    <= CODE1;
      CODE1    <= CODE0;
      CODE0    <= sw_s2;
      VALID    <= {1'b1, VALID[0], VALID[1], VALID[2]};
      if (COUNT != 3'd4) COUNT <= COUNT + 3'd1;
      PUSH_ACK <= 1'b1;
    end else begin
      PUSH_ACK <= 1'b0;
    end
  end

  assign FULL = (COUNT == 3'd4);

endmodule

// File: doc/letter_entry_buffer.md
Name: letter_entry_buffer

Overview:
- Front-end stage for the 7-segment letter display path: debounces the two push-buttons and captures the 6-bit switch letter code on each ENTER press.
- Holds the last four entered codes in a shift buffer; CODE0..CODE3 feed one letter-decoder instance per digit (HEX0..HEX3).
- KEY[1] clears the buffer. Entries beyond four scroll: the oldest letter drops off HEX3.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz); minimum 2.
- CODE_W, 6, letter code width.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET_N  input  1  asynchronous active-low reset.
- SW  input  [0:CODE_W-1]  letter code from switches, same bit order as the decoder input.
- KEY  input  [0:1]  active-low push-buttons: KEY[0] = ENTER, KEY[1] = CLEAR.
- CODE0  output  [0:CODE_W-1]  newest entry, drives the HEX0 decoder.
- CODE1  output  [0:CODE_W-1]  second newest, drives HEX1.
- CODE2  output  [0:CODE_W-1]  third newest, drives HEX2.
- CODE3  output  [0:CODE_W-1]  oldest held, drives HEX3.
- VALID  output  [0:3]  VALID[i]=1 when CODEi holds an entered letter; the decoder blanks the digit when this is 0.
- COUNT  output  3  number of valid entries, 0..4, saturating.
- FULL  output  1  COUNT==4.
- PUSH_ACK  output  1  one-cycle pulse on every accepted ENTER.

Behaviour:
- Reset (RESET_N=0, async): CODE0..3=0, VALID=0, COUNT=0, FULL=0, PUSH_ACK=0. Key synchronizers and debounced levels are set to 1 (released). Debounce counters=0. SW synchronizer=0.
- Synchronizers: KEY[0], KEY[1] and SW each pass through two flops on CLOCK_50. Only the synchronized values are used below.
- Debounce (independent per key):
  - When the synced level equals the debounced level, the counter is cleared to 0.
  - Otherwise the counter increments.
  - On the cycle the counter is DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synced level and the counter is cleared.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press events: a registered one-cycle pulse (enter_p or clear_p) fires on the cycle after a debounced level goes 1->0. Releases (0->1) produce no event. Holding a key produces exactly one event.
- Buffer update, on the clock edge where a pulse is high:
  - clear_p (takes priority over enter_p in the same cycle): CODE0..3=0, VALID=0, COUNT=0. PUSH_ACK stays 0.
  - enter_p alone:
    - Shift: CODE3<=CODE2, CODE2<=CODE1, CODE1<=CODE0, CODE0<=synced SW.
    - VALID<={1,VALID[0],VALID[1],VALID[2]}, i.e. VALID[0]<=1 and each VALID[i]<=VALID[i-1].
    - COUNT<=min(COUNT+1,4).
    - PUSH_ACK=1 for that one cycle.
  - Full buffer and enter_p: the shift still occurs, the old CODE3 is discarded, and COUNT stays 4.
- Any SW value is accepted, including codes the decoder does not map; the decoder shows those as blank.
- FULL is derived from the registered COUNT, not from a separate flop.
- Latency: KEY[0] falls at cycle t and stays low. Synced level changes at t+2, debounced level at t+2+DEBOUNCE_CYCLES, enter_p at t+3+DEBOUNCE_CYCLES. Outputs and PUSH_ACK update at t+4+DEBOUNCE_CYCLES.
- SW changing while KEY[0] is held has no effect until the next press.
- Reset asserted mid-debounce or mid-press: all state returns to reset values immediately. A key still held when reset releases is seen as a new press after a full debounce interval.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
- Reset, then SW=100000, KEY[0] low for 10 cycles, then released -> one PUSH_ACK pulse; CODE0=100000, VALID=1000, COUNT=1, FULL=0; no further change on release.
- KEY[0] bounce: low 3 cycles, high 2, low 3, high -> no PUSH_ACK; all outputs unchanged.
- Five presses with SW=100000,110000,100100,100110,100010 -> after the 4th press FULL=1, CODE3..0=100000,110000,100100,100110. After the 5th press CODE3..0=110000,100100,100110,100010, COUNT=4.
- Three entries, then KEY[1] low for 10 cycles -> CODE0..3=0, VALID=0000, COUNT=0, PUSH_ACK never pulses.
- KEY[0] and KEY[1] pressed on the same cycle with one entry held -> both debounce together; clear wins: COUNT=0, PUSH_ACK=0.
- RESET_N pulsed low for 1 cycle while KEY[0] held with debounce counter at 2 -> outputs 0 immediately. With KEY[0] still held, PUSH_ACK fires at 4+DEBOUNCE_CYCLES cycles after reset release.
